// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths and half-period helper for the SPI clock generator
package spi_pkg;

    localparam int DIV_W = 3;
    localparam int CNT_W = 7;

    // Half-period in clk cycles; one bit wider than the counter so 128 fits.
    function automatic logic [CNT_W:0] half_period(input logic [DIV_W-1:0] div);
        return (CNT_W + 1)'(1) << div;
    endfunction

endpackage

// File: rtl/spi_sclk_gen_if.sv
// rtl/spi_sclk_gen_if.sv - control inputs and SCLK/strobe outputs of the clock generator
interface spi_sclk_gen_if;
    import spi_pkg::*;

    logic [DIV_W-1:0] divider;
    logic             cpol;
    logic             cs;
    logic             sclk;
    logic             sclk_pe;
    logic             sclk_ne;

    modport master (
        output divider,
        output cpol,
        output cs,
        input  sclk,
        input  sclk_pe,
        input  sclk_ne
    );

    modport slave (
        input  divider,
        input  cpol,
        input  cs,
        output sclk,
        output sclk_pe,
        output sclk_ne
    );

endinterface

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered-history edge detector with enable-gated strobes
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    input  logic en,
    output logic pe,
    output logic ne
);

    logic sig_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    // Gating with en suppresses strobes caused by idle-level restores.
    assign pe = sig & ~sig_d & en;
    assign ne = ~sig & sig_d & en;

endmodule

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - power-of-two SCLK divider with CPOL idle level and edge strobes
module spi_sclk_gen
    import spi_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    spi_sclk_gen_if.slave  bus
);

    logic [CNT_W-1:0] cnt;
    logic             sclk_q;
    logic             cs_n;
    logic             at_half;

    // Widened compare: a cnt above the new limit simply counts on and wraps.
    assign at_half = ({1'b0, cnt} == (half_period(bus.divider) - {{CNT_W{1'b0}}, 1'b1}));
    assign cs_n    = ~bus.cs;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sclk_q <= 1'b0;
        end else if (bus.cs) begin
            cnt    <= '0;
            sclk_q <= bus.cpol;
        end else if (at_half) begin
            cnt    <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign bus.sclk = sclk_q;

    edge_detect u_edge_detect (
        .clk (clk),
        .rst (rst),
        .sig (sclk_q),
        .en  (cs_n),
        .pe  (bus.sclk_pe),
        .ne  (bus.sclk_ne)
    );

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb/tb_spi_sclk_gen.sv - self-checking bench for spi_sclk_gen
module tb_spi_sclk_gen;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_sclk_gen_if bus();

    spi_sclk_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: after cs is first sampled low at edge E0, edge E0+k has produced
    // floor((k+1)/half) toggles of the level sclk held when the transfer began.
    bit   m_valid = 1'b0;
    int   m_k     = -1;
    logic m_base  = 1'b0;
    logic m_sclk  = 1'b0;
    logic m_prev  = 1'b0;
    int   m_toggles;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_prev  = 1'b0;
            m_sclk  = 1'b0;
            m_k     = -1;
            m_valid = 1'b1;
        end else begin
            m_prev = m_sclk;
            if (bus.cs) begin
                m_sclk = bus.cpol;
                m_k    = -1;
            end else begin
                if (m_k < 0) begin
                    m_base = m_sclk;
                    m_k    = 0;
                end else begin
                    m_k++;
                end
                m_toggles = (m_k + 1) >> bus.divider;
                m_sclk    = m_base ^ m_toggles[0];
            end
        end
    end

    int pe_cnt, ne_cnt, first_pe, first_ne, last_pe, pe_gap, first_kind, last_kind, alt_bad;

    task automatic clr_stats();
        pe_cnt = 0; ne_cnt = 0; first_pe = -1; first_ne = -1; last_pe = -1;
        pe_gap = -1; first_kind = 0; last_kind = 0; alt_bad = 0;
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("sclk", int'(bus.sclk), int'(m_sclk));
            chk("sclk_pe", int'(bus.sclk_pe), int'(m_sclk & ~m_prev & ~bus.cs));
            chk("sclk_ne", int'(bus.sclk_ne), int'(~m_sclk & m_prev & ~bus.cs));
            if (bus.sclk_pe === 1'b1) begin
                pe_cnt++;
                if (first_pe < 0) first_pe = cyc;
                if (last_pe >= 0) pe_gap = cyc - last_pe;
                last_pe = cyc;
                if (last_kind == 1) alt_bad++;
                last_kind = 1;
                if (first_kind == 0) first_kind = 1;
            end
            if (bus.sclk_ne === 1'b1) begin
                ne_cnt++;
                if (first_ne < 0) first_ne = cyc;
                if (last_kind == 2) alt_bad++;
                last_kind = 2;
                if (first_kind == 0) first_kind = 2;
            end
        end
    end

    // Inputs change just after a falling edge and hold for n rising edges.
    task automatic run(input logic r, input logic c, input logic p, input logic [DIV_W-1:0] d, input int n);
        rst         = r;
        bus.cs      = c;
        bus.cpol    = p;
        bus.divider = d;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    int e0;
    logic [DIV_W-1:0] rd;
    int idle_len, low_len;

    initial begin
        clr_stats();

        run(1'b1, 1'b0, 1'b1, 3'd0, 2);
        chk("reset_sclk", int'(bus.sclk), 0);
        chk("reset_pe", int'(bus.sclk_pe), 0);
        chk("reset_ne", int'(bus.sclk_ne), 0);
        run(1'b0, 1'b1, 1'b1, 3'd0, 1);
        chk("idle_cpol1_sclk", int'(bus.sclk), 1);
        chk("idle_cpol1_ne", int'(bus.sclk_ne), 0);
        chk("idle_cpol1_pe", int'(bus.sclk_pe), 0);

        run(1'b0, 1'b1, 1'b0, 3'd0, 2);
        clr_stats();
        run(1'b0, 1'b0, 1'b0, 3'd0, 8);
        chk("div0_pe_count", pe_cnt, 4);
        chk("div0_ne_count", ne_cnt, 4);
        chk("div0_first_is_pe", first_kind, 1);
        chk("div0_alternate", alt_bad, 0);

        run(1'b0, 1'b1, 1'b0, 3'd2, 2);
        clr_stats();
        e0 = cyc + 1;
        run(1'b0, 1'b0, 1'b0, 3'd2, 40);
        chk("div2_first_toggle", first_pe - e0, 3);
        chk("div2_high_len", first_ne - first_pe, 4);
        chk("div2_pe_spacing", pe_gap, 8);
        chk("div2_pe_count", pe_cnt, 5);

        run(1'b0, 1'b1, 1'b1, 3'd1, 2);
        clr_stats();
        e0 = cyc + 1;
        run(1'b0, 1'b0, 1'b1, 3'd1, 10);
        chk("div1_first_is_ne", first_kind, 2);
        chk("div1_first_ne", first_ne - e0, 1);
        chk("div1_pe_after_ne", first_pe - first_ne, 2);
        chk("div1_ne_count", ne_cnt, 3);
        chk("div1_pe_count", pe_cnt, 2);

        run(1'b0, 1'b1, 1'b0, 3'd3, 2);
        clr_stats();
        e0 = cyc + 1;
        run(1'b0, 1'b0, 1'b0, 3'd3, 8);
        chk("div3_pe_live", int'(bus.sclk_pe), 1);
        chk("div3_first_pe", first_pe - e0, 7);
        bus.cs = 1'b1;
        #1;
        chk("cs_rise_pe_gated", int'(bus.sclk_pe), 0);
        run(1'b0, 1'b1, 1'b0, 3'd3, 1);
        chk("cs_rise_sclk_idle", int'(bus.sclk), 0);
        chk("cs_rise_no_ne", ne_cnt, 0);
        clr_stats();
        e0 = cyc + 1;
        run(1'b0, 1'b0, 1'b0, 3'd3, 10);
        chk("restart_first_pe", first_pe - e0, 7);
        run(1'b1, 1'b0, 1'b0, 3'd3, 1);
        chk("midop_reset_sclk", int'(bus.sclk), 0);

        run(1'b0, 1'b1, 1'b0, 3'd7, 2);
        clr_stats();
        e0 = cyc + 1;
        run(1'b0, 1'b0, 1'b0, 3'd7, 520);
        chk("div7_first_pe", first_pe - e0, 127);
        chk("div7_first_ne", first_ne - e0, 255);
        chk("div7_period", pe_gap, 256);
        chk("div7_pe_count", pe_cnt, 2);
        chk("div7_ne_count", ne_cnt, 2);

        // Random transfers: divider fixed per transfer, cpol free, occasional resets.
        for (int t = 0; t < 150; t++) begin
            rd       = DIV_W'($urandom_range(0, 4));
            idle_len = $urandom_range(1, 4);
            low_len  = $urandom_range(1, 50);
            if ($urandom_range(0, 19) == 0)
                run(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, $urandom_range(1, 2));
            for (int i = 0; i < idle_len; i++)
                run(1'b0, 1'b1, 1'($urandom_range(0, 1)), DIV_W'($urandom_range(0, 7)), 1);
            for (int i = 0; i < low_len; i++) begin
                if ($urandom_range(0, 99) == 0)
                    run(1'b1, 1'b0, 1'($urandom_range(0, 1)), rd, 1);
                else
                    run(1'b0, 1'b0, 1'($urandom_range(0, 1)), rd, 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
